// File: rtl/parking_gate_ctrl_if.sv
// Signal bundle between the parking gate controller and its environment:
// car requests and the pass sensor in, gate actuator and slot status out.
interface parking_gate_ctrl_if;
    logic       entry_req;
    logic       exit_req;
    logic [1:0] exit_slot;
    logic       pass_sensor;
    logic       gate_open;
    logic       entry_grant;
    logic       exit_grant;
    logic [1:0] assigned_slot;
    logic       car1_state;
    logic       car2_state;
    logic       car3_state;
    logic       entry_reject;
    logic       exit_err;

    modport master (
        output entry_req, exit_req, exit_slot, pass_sensor,
        input  gate_open, entry_grant, exit_grant, assigned_slot,
               car1_state, car2_state, car3_state, entry_reject, exit_err
    );

    modport slave (
        input  entry_req, exit_req, exit_slot, pass_sensor,
        output gate_open, entry_grant, exit_grant, assigned_slot,
               car1_state, car2_state, car3_state, entry_reject, exit_err
    );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Single-lane parking gate sequencer for a three-slot lot: arbitrates entry and
// exit requests, times the open gate, and tracks which slots hold a car.
//
// state    | meaning
// IDLE     | gate closed, sampling entry/exit requests
// OPEN_IN  | gate open for an entering car, waiting for pass_sensor or timeout
// OPEN_OUT | gate open for an exiting car, waiting for pass_sensor or timeout
// CLOSE    | gate closed, hold-off of CLOSE_CYCLES before the next grant
module parking_gate_ctrl #(
    parameter int unsigned TIMEOUT      = 8,
    parameter int unsigned CLOSE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    parking_gate_ctrl_if.slave gate
);
    typedef enum logic [1:0] {IDLE, OPEN_IN, OPEN_OUT, CLOSE} state_t;

    localparam logic [7:0] OPEN_LAST    = 8'(TIMEOUT - 1);
    localparam logic [3:0] CLOSE_LOAD   = 4'(CLOSE_CYCLES - 1);
    localparam logic       SERVED_EXIT  = 1'b0;
    localparam logic       SERVED_ENTRY = 1'b1;

    state_t     state;
    logic [7:0] open_cnt;
    logic [3:0] close_cnt;
    logic       last_served;
    logic [2:0] occupied;
    logic [1:0] slot_q;
    logic [1:0] exit_slot_q;
    logic       gate_open_q;
    logic       entry_grant_q;
    logic       exit_grant_q;
    logic       exit_err_q;

    logic [3:0] occupied_ext;
    logic       full;
    logic       exit_valid;
    logic       entry_ok;
    logic       exit_ok;
    logic       pick_entry;
    logic       pick_exit;
    logic       open_done;
    logic [1:0] free_slot;

    always_comb begin
        // Index 3 reads the padding bit, so it never names an occupied slot.
        occupied_ext = {1'b0, occupied};
        full         = &occupied;
        exit_valid   = occupied_ext[gate.exit_slot];
        entry_ok     = gate.entry_req && !full;
        exit_ok      = gate.exit_req && exit_valid;
        pick_entry   = entry_ok && (!exit_ok || (last_served == SERVED_EXIT));
        pick_exit    = exit_ok && !pick_entry;
        open_done    = gate.pass_sensor || (open_cnt == OPEN_LAST);
        free_slot    = 2'd2;
        if (!occupied[1]) free_slot = 2'd1;
        if (!occupied[0]) free_slot = 2'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            open_cnt      <= 8'd0;
            close_cnt     <= 4'd0;
            last_served   <= SERVED_EXIT;
            occupied      <= 3'b000;
            slot_q        <= 2'd0;
            exit_slot_q   <= 2'd0;
            gate_open_q   <= 1'b0;
            entry_grant_q <= 1'b0;
            exit_grant_q  <= 1'b0;
            exit_err_q    <= 1'b0;
        end else begin
            entry_grant_q <= 1'b0;
            exit_grant_q  <= 1'b0;
            exit_err_q    <= 1'b0;
            case (state)
                IDLE: begin
                    exit_err_q <= gate.exit_req && !exit_valid;
                    if (pick_entry) begin
                        state         <= OPEN_IN;
                        open_cnt      <= 8'd0;
                        slot_q        <= free_slot;
                        last_served   <= SERVED_ENTRY;
                        gate_open_q   <= 1'b1;
                        entry_grant_q <= 1'b1;
                    end else if (pick_exit) begin
                        state        <= OPEN_OUT;
                        open_cnt     <= 8'd0;
                        exit_slot_q  <= gate.exit_slot;
                        last_served  <= SERVED_EXIT;
                        gate_open_q  <= 1'b1;
                        exit_grant_q <= 1'b1;
                    end
                end
                OPEN_IN, OPEN_OUT: begin
                    if (open_done) begin
                        // A pass on the timeout cycle still commits the slot.
                        if (gate.pass_sensor) begin
                            if (state == OPEN_IN) occupied[slot_q] <= 1'b1;
                            else                  occupied[exit_slot_q] <= 1'b0;
                        end
                        state       <= CLOSE;
                        open_cnt    <= 8'd0;
                        close_cnt   <= CLOSE_LOAD;
                        gate_open_q <= 1'b0;
                    end else begin
                        open_cnt <= open_cnt + 8'd1;
                    end
                end
                CLOSE: begin
                    if (close_cnt == 4'd0) state <= IDLE;
                    else                   close_cnt <= close_cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign gate.gate_open     = gate_open_q;
    assign gate.entry_grant   = entry_grant_q;
    assign gate.exit_grant    = exit_grant_q;
    assign gate.exit_err      = exit_err_q;
    assign gate.assigned_slot = slot_q;
    assign gate.car1_state    = occupied[0];
    assign gate.car2_state    = occupied[1];
    assign gate.car3_state    = occupied[2];
    assign gate.entry_reject  = (state == IDLE) && !reset && gate.entry_req && full;
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: directed scenarios plus a randomized run checked
// against a transaction-level model of the lot (slot table, gate age, hold-off).
module tb_parking_gate_ctrl;
    localparam int TIMEOUT      = 8;
    localparam int CLOSE_CYCLES = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    parking_gate_ctrl_if gif();

    parking_gate_ctrl #(.TIMEOUT(TIMEOUT), .CLOSE_CYCLES(CLOSE_CYCLES)) dut (
        .clk  (clk),
        .reset(reset),
        .gate (gif.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Model: phase 0 = waiting, 1 = entering car, 2 = leaving car, 3 = hold-off.
    int  m_phase = 0;
    int  m_age = 0;
    int  m_close_left = 0;
    bit  m_occ[3] = '{0, 0, 0};
    bit  m_last_entry = 0;
    int  m_slot = 0;
    int  m_xslot = 0;
    bit  m_slot_valid = 0;
    bit  m_gate = 0, m_eg = 0, m_xg = 0, m_err = 0;

    function automatic void model_update(bit rst, bit e, bit x, int xs, bit p);
        bit any_free, entry_ok, exit_ok;
        m_eg = 0; m_xg = 0; m_err = 0;
        if (rst) begin
            m_phase = 0; m_occ = '{0, 0, 0}; m_last_entry = 0;
            m_gate = 0; m_slot_valid = 0;
            return;
        end
        case (m_phase)
            0: begin
                any_free = !(m_occ[0] && m_occ[1] && m_occ[2]);
                entry_ok = e && any_free;
                exit_ok  = x && ((xs < 3) ? m_occ[xs] : 1'b0);
                m_err    = x && !exit_ok;
                if (entry_ok && (!exit_ok || !m_last_entry)) begin
                    for (int i = 2; i >= 0; i--) if (!m_occ[i]) m_slot = i;
                    m_slot_valid = 1; m_phase = 1; m_age = 1; m_gate = 1; m_eg = 1;
                    m_last_entry = 1;
                end else if (exit_ok) begin
                    m_xslot = xs; m_slot_valid = 0; m_phase = 2; m_age = 1; m_gate = 1;
                    m_xg = 1; m_last_entry = 0;
                end
            end
            1, 2: begin
                if (p || m_age == TIMEOUT) begin
                    if (p) begin
                        if (m_phase == 1) m_occ[m_slot] = 1;
                        else              m_occ[m_xslot] = 0;
                    end
                    m_phase = 3; m_close_left = CLOSE_CYCLES; m_gate = 0;
                end else begin
                    m_age++;
                end
            end
            default: begin
                m_close_left--;
                if (m_close_left == 0) begin m_phase = 0; m_slot_valid = 0; end
            end
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        model_update(reset, gif.entry_req, gif.exit_req, int'(gif.exit_slot), gif.pass_sensor);
        #1;
    endtask

    task automatic drive(bit e, bit x, logic [1:0] xs, bit p);
        gif.entry_req   = e;
        gif.exit_req    = x;
        gif.exit_slot   = xs;
        gif.pass_sensor = p;
    endtask

    task automatic do_entry();
        drive(1, 0, 2'd0, 0); step();
        drive(0, 0, 2'd0, 1); step();
        drive(0, 0, 2'd0, 0); repeat (CLOSE_CYCLES) step();
    endtask

    task automatic do_exit(logic [1:0] s);
        drive(0, 1, s, 0); step();
        drive(0, 0, 2'd0, 1); step();
        drive(0, 0, 2'd0, 0); repeat (CLOSE_CYCLES) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1, 1, 2'd3, 1);
        step(); step();
        checks++; if (gif.gate_open !== 1'b0) begin errors++; $display("FAIL reset_gate_open got %b want 0", gif.gate_open); end
        checks++; if (gif.entry_grant !== 1'b0) begin errors++; $display("FAIL reset_entry_grant got %b want 0", gif.entry_grant); end
        checks++; if (gif.exit_grant !== 1'b0) begin errors++; $display("FAIL reset_exit_grant got %b want 0", gif.exit_grant); end
        checks++; if (gif.exit_err !== 1'b0) begin errors++; $display("FAIL reset_exit_err got %b want 0", gif.exit_err); end
        checks++; if (gif.entry_reject !== 1'b0) begin errors++; $display("FAIL reset_entry_reject got %b want 0", gif.entry_reject); end
        checks++; if (gif.assigned_slot !== 2'd0) begin errors++; $display("FAIL reset_assigned_slot got %0d want 0", gif.assigned_slot); end
        checks++; if ({gif.car3_state, gif.car2_state, gif.car1_state} !== 3'b000) begin errors++; $display("FAIL reset_cars got %b want 000", {gif.car3_state, gif.car2_state, gif.car1_state}); end
        drive(0, 0, 2'd0, 0);
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_entry();
        drive(1, 0, 2'd0, 0); step();
        checks++; if (gif.entry_grant !== 1'b1) begin errors++; $display("FAIL single_grant got %b want 1", gif.entry_grant); end
        checks++; if (gif.gate_open !== 1'b1) begin errors++; $display("FAIL single_gate_open got %b want 1", gif.gate_open); end
        checks++; if (gif.assigned_slot !== 2'd0) begin errors++; $display("FAIL single_slot got %0d want 0", gif.assigned_slot); end
        drive(0, 0, 2'd0, 0); step();
        checks++; if (gif.entry_grant !== 1'b0 || gif.gate_open !== 1'b1) begin errors++; $display("FAIL single_cycle2 grant %b gate %b want 0 1", gif.entry_grant, gif.gate_open); end
        step();
        drive(0, 0, 2'd0, 1); step();
        checks++; if (gif.car1_state !== 1'b1 || gif.gate_open !== 1'b0) begin errors++; $display("FAIL single_commit car1 %b gate %b want 1 0", gif.car1_state, gif.gate_open); end
        drive(0, 0, 2'd0, 0); step();
        drive(1, 0, 2'd0, 0); step();
        checks++; if (gif.entry_grant !== 1'b0) begin errors++; $display("FAIL close_ignores_req got %b want 0", gif.entry_grant); end
        step();
        checks++; if (gif.entry_grant !== 1'b1 || gif.assigned_slot !== 2'd1) begin errors++; $display("FAIL idle_at_cycle6 grant %b slot %0d want 1 1", gif.entry_grant, gif.assigned_slot); end
        drive(0, 0, 2'd0, 1); step();
        drive(0, 0, 2'd0, 0); repeat (CLOSE_CYCLES) step();
    endtask

    task automatic test_full_reject();
        do_entry();
        checks++; if ({gif.car3_state, gif.car2_state, gif.car1_state} !== 3'b111) begin errors++; $display("FAIL fill_order got %b want 111", {gif.car3_state, gif.car2_state, gif.car1_state}); end
        drive(1, 0, 2'd0, 0); #1;
        checks++; if (gif.entry_reject !== 1'b1) begin errors++; $display("FAIL full_reject got %b want 1", gif.entry_reject); end
        step();
        checks++; if (gif.entry_grant !== 1'b0 || gif.gate_open !== 1'b0) begin errors++; $display("FAIL full_no_grant grant %b gate %b want 0 0", gif.entry_grant, gif.gate_open); end
        step();
        checks++; if (gif.gate_open !== 1'b0 || gif.entry_reject !== 1'b1) begin errors++; $display("FAIL full_held gate %b reject %b want 0 1", gif.gate_open, gif.entry_reject); end
        drive(0, 0, 2'd0, 0); step();
    endtask

    task automatic test_round_robin();
        bit exp_entry;
        int n;
        do_exit(2'd0);
        do_exit(2'd2);
        checks++; if ({gif.car3_state, gif.car2_state, gif.car1_state} !== 3'b010) begin errors++; $display("FAIL rr_setup got %b want 010", {gif.car3_state, gif.car2_state, gif.car1_state}); end
        drive(1, 1, 2'd1, 0);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(gif.entry_grant || gif.exit_grant) && n < 20) begin step(); n++; end
            checks++; if (n >= 20) begin errors++; $display("FAIL rr_wait_%0d no grant after %0d cycles want a grant", k, n); end
            exp_entry = (k % 2 == 0);
            checks++; if (gif.entry_grant !== exp_entry || gif.exit_grant !== !exp_entry) begin errors++; $display("FAIL rr_order_%0d entry %b exit %b want %b %b", k, gif.entry_grant, gif.exit_grant, exp_entry, !exp_entry); end
            if (k == 1) gif.exit_slot = 2'd0;
            gif.pass_sensor = 1'b1; step(); gif.pass_sensor = 1'b0;
            if (k == 1) begin
                checks++; if ({gif.car2_state, gif.car1_state} !== 2'b01) begin errors++; $display("FAIL exit_slot_latched car2/car1 %b want 01", {gif.car2_state, gif.car1_state}); end
            end
        end
        drive(0, 0, 2'd0, 0); repeat (CLOSE_CYCLES) step();
    endtask

    task automatic test_timeout();
        int cnt = 0;
        drive(1, 0, 2'd0, 0); step();
        checks++; if (gif.entry_grant !== 1'b1 || gif.assigned_slot !== 2'd0) begin errors++; $display("FAIL timeout_grant grant %b slot %0d want 1 0", gif.entry_grant, gif.assigned_slot); end
        drive(0, 0, 2'd0, 0);
        while (gif.gate_open && cnt < 40) begin cnt++; step(); end
        checks++; if (cnt != TIMEOUT) begin errors++; $display("FAIL timeout_open_cycles got %0d want %0d", cnt, TIMEOUT); end
        checks++; if (gif.car1_state !== 1'b0) begin errors++; $display("FAIL timeout_no_commit car1 %b want 0", gif.car1_state); end
        repeat (CLOSE_CYCLES) step();
    endtask

    task automatic test_exit_err();
        drive(0, 1, 2'd3, 0); step();
        checks++; if (gif.exit_err !== 1'b1 || gif.exit_grant !== 1'b0 || gif.gate_open !== 1'b0) begin errors++; $display("FAIL err_index3 err %b grant %b gate %b want 1 0 0", gif.exit_err, gif.exit_grant, gif.gate_open); end
        drive(0, 1, 2'd0, 0); step();
        checks++; if (gif.exit_err !== 1'b1 || gif.exit_grant !== 1'b0 || gif.gate_open !== 1'b0) begin errors++; $display("FAIL err_empty err %b grant %b gate %b want 1 0 0", gif.exit_err, gif.exit_grant, gif.gate_open); end
        drive(0, 0, 2'd0, 0); step();
        checks++; if (gif.exit_err !== 1'b0 || gif.gate_open !== 1'b0) begin errors++; $display("FAIL err_pulse_end err %b gate %b want 0 0", gif.exit_err, gif.gate_open); end
        drive(1, 1, 2'd2, 0); step();
        checks++; if (gif.entry_grant !== 1'b1 || gif.exit_err !== 1'b1) begin errors++; $display("FAIL err_with_entry grant %b err %b want 1 1", gif.entry_grant, gif.exit_err); end
        drive(0, 0, 2'd0, 1); step();
        drive(0, 0, 2'd0, 0); repeat (CLOSE_CYCLES) step();
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 2'd0, 0); step();
        checks++; if (gif.entry_grant !== 1'b1 || gif.assigned_slot !== 2'd2) begin errors++; $display("FAIL mid_grant grant %b slot %0d want 1 2", gif.entry_grant, gif.assigned_slot); end
        step();
        reset = 1'b1; step();
        checks++; if (gif.gate_open !== 1'b0 || gif.entry_grant !== 1'b0 || gif.assigned_slot !== 2'd0) begin errors++; $display("FAIL mid_reset gate %b grant %b slot %0d want 0 0 0", gif.gate_open, gif.entry_grant, gif.assigned_slot); end
        checks++; if ({gif.car3_state, gif.car2_state, gif.car1_state} !== 3'b000) begin errors++; $display("FAIL mid_reset_cars got %b want 000", {gif.car3_state, gif.car2_state, gif.car1_state}); end
        reset = 1'b0; step();
        checks++; if (gif.entry_grant !== 1'b1 || gif.assigned_slot !== 2'd0) begin errors++; $display("FAIL mid_resample grant %b slot %0d want 1 0", gif.entry_grant, gif.assigned_slot); end
        drive(0, 0, 2'd0, 1); step();
        drive(0, 0, 2'd0, 0); repeat (CLOSE_CYCLES) step();
    endtask

    task automatic test_random();
        bit exp_rej;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4,
                  2'($urandom_range(0, 3)), $urandom_range(0, 9) < 2);
            #1;
            exp_rej = (m_phase == 0) && !reset && gif.entry_req && m_occ[0] && m_occ[1] && m_occ[2];
            checks++; if (gif.entry_reject !== exp_rej) begin errors++; $display("FAIL rnd_reject cycle %0d got %b want %b", c, gif.entry_reject, exp_rej); end
            step();
            checks++; if (gif.gate_open !== m_gate) begin errors++; $display("FAIL rnd_gate cycle %0d got %b want %b", c, gif.gate_open, m_gate); end
            checks++; if (gif.entry_grant !== m_eg || gif.exit_grant !== m_xg) begin errors++; $display("FAIL rnd_grants cycle %0d got %b%b want %b%b", c, gif.entry_grant, gif.exit_grant, m_eg, m_xg); end
            checks++; if (gif.exit_err !== m_err) begin errors++; $display("FAIL rnd_exit_err cycle %0d got %b want %b", c, gif.exit_err, m_err); end
            checks++; if ({gif.car3_state, gif.car2_state, gif.car1_state} !== {m_occ[2], m_occ[1], m_occ[0]}) begin errors++; $display("FAIL rnd_cars cycle %0d got %b want %b", c, {gif.car3_state, gif.car2_state, gif.car1_state}, {m_occ[2], m_occ[1], m_occ[0]}); end
            if (m_slot_valid) begin
                checks++; if (gif.assigned_slot !== 2'(m_slot)) begin errors++; $display("FAIL rnd_slot cycle %0d got %0d want %0d", c, gif.assigned_slot, m_slot); end
            end
        end
        reset = 1'b0;
        drive(0, 0, 2'd0, 0);
    endtask

    initial begin
        drive(0, 0, 2'd0, 0);
        #1;
        test_reset();
        test_single_entry();
        test_full_reject();
        test_round_robin();
        test_timeout();
        test_exit_err();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
